approx_mult_pipe: RTL

// - Pipelined, parametrised 2H x 2H approximate multiplier.
// - Operands are split into H-bit halves, giving four sub-products.
// - Each sub-product has a per-transaction approximation level.
// - Sub-products are summed by an optional lower-part-OR adder (LOA).
// - Successor to the fixed 8x8 quadrant multipliers: adds width generality, runtime level select,
//   a valid/ready pipeline and back-pressure. Sits between the operand source and the accuracy/energy evaluation harness.

---
 rtl/approx_mult_pkg.sv | 38 +++
 rtl/approx_sub_mult.sv | 23 ++
 rtl/approx_mult_pipe.sv | 125 ++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier pipeline.
// Contents: approximation level constants, in_cfg field layout, quadrant
// identifiers with their alignment weights, and the LSB truncation helper
// used by every sub-multiplier.
package approx_mult_pkg;

  localparam int unsigned LVL_W       = 2;
  localparam int unsigned CFG_LOA_BIT = 8;
  localparam int unsigned CFG_W       = 9;
  localparam int unsigned NUM_QUAD    = 4;

  localparam logic [LVL_W-1:0] LVL_EXACT = 2'd0;
  localparam logic [LVL_W-1:0] LVL_MAX   = 2'd3;

  // Quadrant naming: first letter is the half of A, second the half of B.
  typedef enum logic [1:0] {
    QUAD_LL = 2'd0,
    QUAD_LH = 2'd1,
    QUAD_HL = 2'd2,
    QUAD_HH = 2'd3
  } quad_e;

  // Bit position of a quadrant's sub-product within the full product.
  function automatic int unsigned quad_weight(input quad_e q, input int unsigned h);
    case (q)
      QUAD_LL: return 0;
      QUAD_HH: return 2 * h;
      default: return h;
    endcase
  endfunction

  // Clears the k LSBs of a sub-product (k = 0 leaves it exact).
  function automatic logic [63:0] level_trunc(input logic [63:0] prod,
                                              input logic [LVL_W-1:0] k);
    return prod & ~((64'd1 << k) - 64'd1);
  endfunction

endpackage

// File: rtl/approx_sub_mult.sv
// H x H exact multiplier followed by level-controlled LSB truncation.
// Ports:
//   a_i, b_i : H-bit operand halves
//   lvl_i    : approximation level, number of result LSBs forced to 0
//   p_o      : 2H-bit levelled sub-product
// Purely combinational; H is limited to 32 by the 64-bit truncation helper.
module approx_sub_mult
  import approx_mult_pkg::*;
#(
  parameter int H = 4
) (
  input  logic [H-1:0]     a_i,
  input  logic [H-1:0]     b_i,
  input  logic [LVL_W-1:0] lvl_i,
  output logic [2*H-1:0]   p_o
);

  logic [2*H-1:0] exact;

  assign exact = {{H{1'b0}}, a_i} * {{H{1'b0}}, b_i};
  assign p_o   = (2*H)'(level_trunc(64'(exact), lvl_i));

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined 2H x 2H approximate multiplier with valid/ready handshaking.
// Operands are split into H-bit halves; each of the four sub-products is
// truncated by its own level from in_cfg, then the aligned terms are summed,
// optionally with a lower-part-OR adder over the LOA_BITS result LSBs.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand beat handshake
//   in_a, in_b           : 2H-bit operands
//   in_cfg               : [2q+1:2q] level of quadrant q, [8] LOA enable
//   out_valid/out_ready  : result handshake
//   out_r                : 4H-bit approximate product
//   busy                 : any pipeline stage holds a valid beat
// Stages: S1 captures operands/cfg, S2 holds levelled sub-products and the
// LOA bit, S3 holds the result.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int H        = 4,
  parameter int LOA_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*H-1:0]   in_a,
  input  logic [2*H-1:0]   in_b,
  input  logic [CFG_W-1:0] in_cfg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*H-1:0]   out_r,
  output logic             busy
);

  localparam int W = 4 * H;
  localparam logic [W-1:0] LO_MASK = (W'(1) << LOA_BITS) - W'(1);

  logic             v1_q, v2_q, v3_q;
  logic [2*H-1:0]   a_q, b_q;
  logic [CFG_W-1:0] cfg_q;
  logic [2*H-1:0]   p_d [NUM_QUAD];
  logic [2*H-1:0]   p_q [NUM_QUAD];
  logic             loa_q;
  logic [W-1:0]     r_d, r_q;

  logic adv1, adv2, adv3;

  // Ready chain runs strictly downstream-to-upstream: out_ready -> adv3 ->
  // adv2 -> adv1. Empty stages advance regardless, so bubbles collapse.
  assign adv3     = ~v3_q | out_ready;
  assign adv2     = ~v2_q | adv3;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  assign out_valid = v3_q;
  assign out_r     = r_q;
  assign busy      = v1_q | v2_q | v3_q;

  // Four sub-multipliers on the S1 registers feed the S2 registers.
  for (genvar q = 0; q < NUM_QUAD; q++) begin : g_quad
    logic [H-1:0] qa, qb;
    assign qa = (q >= 2)    ? a_q[2*H-1:H] : a_q[H-1:0];
    assign qb = (q % 2 == 1) ? b_q[2*H-1:H] : b_q[H-1:0];

    approx_sub_mult #(.H(H)) u_sub (
      .a_i   (qa),
      .b_i   (qb),
      .lvl_i (cfg_q[2*q +: LVL_W]),
      .p_o   (p_d[q])
    );
  end

  // With LOA off (or LOA_BITS=0, where LO_MASK is 0) this reduces to the
  // plain modular sum of the aligned terms.
  always_comb begin
    logic [W-1:0] t;
    logic [W-1:0] exact_sum;
    logic [W-1:0] hi_sum;
    logic [W-1:0] lo_or;
    exact_sum = '0;
    hi_sum    = '0;
    lo_or     = '0;
    for (int unsigned q = 0; q < NUM_QUAD; q++) begin
      t         = W'(p_q[q]) << quad_weight(quad_e'(q), H);
      exact_sum = exact_sum + t;
      hi_sum    = hi_sum + (t >> LOA_BITS);
      lo_or     = lo_or | (t & LO_MASK);
    end
    r_d = loa_q ? ((hi_sum << LOA_BITS) | lo_or) : exact_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cfg_q <= '0;
      for (int unsigned q = 0; q < NUM_QUAD; q++) p_q[q] <= '0;
      loa_q <= 1'b0;
      r_q   <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          cfg_q <= in_cfg;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          for (int unsigned q = 0; q < NUM_QUAD; q++) p_q[q] <= p_d[q];
          loa_q <= cfg_q[CFG_LOA_BIT];
        end
      end
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) r_q <= r_d;
      end
    end
  end

endmodule
